pulse_train_gen: RTL and testbench

- Multi-channel, parametrised successor of the single-pulse generator.
- Each channel emits a programmable train on a start rising edge: delay, then COUNT pulses of WIDTH high cycles, repeating every PERIOD cycles.
- Sits between the control/register block (supplies timing words and start) and the optical driver outputs. Channels are fully independent.

---
 rtl/pulse_train_gen.sv | 182 ++++++++++++++++++
 tb/tb_pulse_train_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_train_gen.sv
// Multi-channel programmable pulse-train generator: delay, then COUNT pulses of WIDTH cycles every PERIOD.
// Optional macro PULSE_INVERT_EN adds a live per-channel output inversion input `inv`.
module pulse_train_ch #(
    parameter int CW = 32,
    parameter int NW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] delay,
    input  logic [CW-1:0] width,
    input  logic [CW-1:0] period,
    input  logic [NW-1:0] count,
`ifdef PULSE_INVERT_EN
    input  logic          inv,
`endif
    output logic          out,
    output logic          busy,
    output logic          done
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DELAY = 2'd1;
    localparam logic [1:0] S_HIGH  = 2'd2;
    localparam logic [1:0] S_LOW   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] tmr_q, tmr_d, dly_q, dly_d, wid_q, wid_d, low_q, low_d;
    logic [NW-1:0] num_q, num_d, pcnt_q, pcnt_d;
    logic          prev_q, prev_d, armed_q, armed_d, fin_q, fin_d;
    logic          out_q, out_d, busy_q, busy_d, done_q, done_d;
    logic          trig, inv_bit;

`ifdef PULSE_INVERT_EN
    assign inv_bit = inv;
`else
    assign inv_bit = 1'b0;
`endif

    // armed_q keeps a start held high through reset from looking like a fresh rising edge
    assign trig = start && !prev_q && armed_q;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        dly_d   = dly_q;
        wid_d   = wid_q;
        low_d   = low_q;
        num_d   = num_q;
        pcnt_d  = pcnt_q;
        fin_d   = 1'b0;
        prev_d  = start;
        armed_d = armed_q | ~start;
        case (state_q)
            S_IDLE: begin
                if (trig) begin
                    dly_d  = delay;
                    wid_d  = width;
                    low_d  = (period > width) ? (period - width) : CW'(1);
                    num_d  = count;
                    tmr_d  = '0;
                    pcnt_d = '0;
                    if (width == '0)      fin_d   = 1'b1;
                    else if (delay == '0) state_d = S_HIGH;
                    else                  state_d = S_DELAY;
                end
            end
            S_DELAY: begin
                if (tmr_q == dly_q - CW'(1)) begin
                    tmr_d   = '0;
                    state_d = S_HIGH;
                end else begin
                    tmr_d = tmr_q + CW'(1);
                end
            end
            S_HIGH: begin
                if (tmr_q == wid_q - CW'(1)) begin
                    tmr_d  = '0;
                    pcnt_d = pcnt_q + NW'(1);
                    if (num_q != '0 && pcnt_q + NW'(1) == num_q) begin
                        state_d = S_IDLE;
                        fin_d   = 1'b1;
                    end else begin
                        state_d = S_LOW;
                    end
                end else begin
                    tmr_d = tmr_q + CW'(1);
                end
            end
            S_LOW: begin
                if (tmr_q == low_q - CW'(1)) begin
                    tmr_d   = '0;
                    state_d = S_HIGH;
                end else begin
                    tmr_d = tmr_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE && !start) begin
            state_d = S_IDLE;
            fin_d   = 1'b0;
        end
        // outputs are one register stage behind the state
        out_d  = (state_q == S_HIGH) ^ inv_bit;
        busy_d = (state_q != S_IDLE);
        done_d = fin_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            dly_q   <= '0;
            wid_q   <= '0;
            low_q   <= '0;
            num_q   <= '0;
            pcnt_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            fin_q   <= 1'b0;
            out_q   <= inv_bit;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            dly_q   <= dly_d;
            wid_q   <= wid_d;
            low_q   <= low_d;
            num_q   <= num_d;
            pcnt_q  <= pcnt_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            fin_q   <= fin_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

module pulse_train_gen #(
    parameter int CH = 4,
    parameter int CW = 32,
    parameter int NW = 16
) (
    input  logic             clk_Pulse,
    input  logic             rst,
    input  logic [CH-1:0]    start,
    input  logic [CH*CW-1:0] delay,
    input  logic [CH*CW-1:0] width,
    input  logic [CH*CW-1:0] period,
    input  logic [CH*NW-1:0] count,
`ifdef PULSE_INVERT_EN
    input  logic [CH-1:0]    inv,
`endif
    output logic [CH-1:0]    out,
    output logic [CH-1:0]    busy,
    output logic [CH-1:0]    done
);
    for (genvar i = 0; i < CH; i++) begin : g_ch
        pulse_train_ch #(.CW(CW), .NW(NW)) u_ch (
            .clk    (clk_Pulse),
            .rst    (rst),
            .start  (start[i]),
            .delay  (delay[i*CW +: CW]),
            .width  (width[i*CW +: CW]),
            .period (period[i*CW +: CW]),
            .count  (count[i*NW +: NW]),
`ifdef PULSE_INVERT_EN
            .inv    (inv[i]),
`endif
            .out    (out[i]),
            .busy   (busy[i]),
            .done   (done[i])
        );
    end
endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: per-edge expectations from an arithmetic train model,
// popped and compared by an independent monitor. Honors PULSE_INVERT_EN if defined.
module tb_pulse_train_gen;
    localparam int CH = 4;
    localparam int CW = 32;
    localparam int NW = 16;

    logic             clk_Pulse = 1'b0;
    logic             rst = 1'b1;
    logic [CH-1:0]    start = '0;
    logic [CH*CW-1:0] delay = '0, width = '0, period = '0;
    logic [CH*NW-1:0] count = '0;
    logic [CH-1:0]    out, busy, done;
`ifdef PULSE_INVERT_EN
    logic [CH-1:0]    inv = 4'b0101;
`else
    logic [CH-1:0]    inv = '0;
`endif

    pulse_train_gen #(.CH(CH), .CW(CW), .NW(NW)) dut (
        .clk_Pulse (clk_Pulse),
        .rst       (rst),
        .start     (start),
        .delay     (delay),
        .width     (width),
        .period    (period),
        .count     (count),
`ifdef PULSE_INVERT_EN
        .inv       (inv),
`endif
        .out       (out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_Pulse = ~clk_Pulse;

    typedef struct {
        longint        c;
        logic [CH-1:0] o, b, d;
    } exp_t;
    exp_t exp_q[$];

    int n_chk = 0, n_fail = 0;
    longint cyc = 0;

    // model state: trigger edge, abort edge, latched parameters, edge-detect history
    longint t0[CH], ta[CH], m_dly[CH], m_wid[CH], m_per[CH], m_num[CH];
    logic   prev[CH], seen_low[CH];

    function automatic logic [2:0] obs(int i, longint c);
        longint k, p, last, m;
        logic o, b, d;
        o = 1'b0; b = 1'b0; d = 1'b0;
        if (t0[i] >= 0 && c <= ta[i]) begin
            k = c - t0[i];
            if (k >= 1) begin
                if (m_wid[i] == 0) begin
                    d = (k == 1);
                end else begin
                    p    = (m_per[i] > m_wid[i]) ? m_per[i] : m_wid[i] + 1;
                    last = m_dly[i] + (m_num[i] - 1) * p + m_wid[i];
                    if (m_num[i] == 0 || k <= last) begin
                        b = 1'b1;
                        if (k > m_dly[i]) begin
                            m = (k - 1 - m_dly[i]) % p;
                            o = (m < m_wid[i]);
                        end
                    end else begin
                        d = (k == last + 1);
                    end
                end
            end
        end
        return {o, b, d};
    endfunction

    // Apply the inputs about to be sampled at the next edge to the model, then queue what
    // the DUT must show right after that edge.
    task automatic model_edge();
        exp_t e;
        logic [2:0] r;
        longint c;
        c = cyc + 1;
        for (int i = 0; i < CH; i++) begin
            if (rst) begin
                t0[i] = -1; prev[i] = 1'b0; seen_low[i] = 1'b0;
            end else begin
                r = obs(i, c);
                if (!start[i] && r[1]) ta[i] = c;
                if (start[i] && !prev[i] && seen_low[i]) begin
                    t0[i]    = c;
                    ta[i]    = 64'h7fff_ffff_ffff_ffff;
                    m_dly[i] = longint'(delay[i*CW +: CW]);
                    m_wid[i] = longint'(width[i*CW +: CW]);
                    m_per[i] = longint'(period[i*CW +: CW]);
                    m_num[i] = longint'(count[i*NW +: NW]);
                end
                if (!start[i]) seen_low[i] = 1'b1;
                prev[i] = start[i];
            end
        end
        e.c = c;
        for (int i = 0; i < CH; i++) begin
            r = obs(i, c);
            e.o[i] = r[2] ^ inv[i];
            e.b[i] = r[1];
            e.d[i] = r[0];
        end
        exp_q.push_back(e);
        cyc = c;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk_Pulse);
        @(negedge clk_Pulse);
    endtask

    task automatic run(int n);
        for (int j = 0; j < n; j++) step();
    endtask

    task automatic set_ch(int i, int d, int w, int p, int n);
        delay[i*CW +: CW]  = CW'(d);
        width[i*CW +: CW]  = CW'(w);
        period[i*CW +: CW] = CW'(p);
        count[i*NW +: NW]  = NW'(n);
    endtask

    task automatic check(string name, longint c, logic [CH-1:0] got, logic [CH-1:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, c, got, want);
        end
    endtask

    // monitor: every clock edge the DUT presents a new output vector
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_Pulse);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out", e.c, out, e.o);
                check("busy", e.c, busy, e.b);
                check("done", e.c, done, e.d);
            end
        end
    end

    initial begin
        for (int i = 0; i < CH; i++) begin
            t0[i] = -1; ta[i] = 0; prev[i] = 1'b0; seen_low[i] = 1'b0;
            m_dly[i] = 0; m_wid[i] = 0; m_per[i] = 0; m_num[i] = 0;
        end
        // start held high through reset and after it must not trigger
        rst = 1'b1; start = 4'b1111;
        for (int i = 0; i < CH; i++) set_ch(i, 1, 2, 3, 1);
        run(3);
        rst = 1'b0;
        run(6);
        start = '0;
        run(2);
        // ch0 finite train alongside ch3 zero-width trigger on the same edge
        set_ch(0, 3, 2, 5, 3);
        set_ch(3, 5, 0, 4, 2);
        start = 4'b1001;
        run(2);
        set_ch(0, 1, 1, 1, 1);
        set_ch(3, 0, 3, 3, 0);
        run(20);
        start = '0;
        run(2);
        // ch1 period shorter than width clamps to a single low cycle
        set_ch(1, 0, 4, 2, 2);
        start = 4'b0010;
        run(14);
        start = '0;
        run(2);
        // ch2 continuous train aborted while high
        set_ch(2, 0, 1, 3, 0);
        start = 4'b0100;
        run(100);
        start = '0;
        run(4);
        // mid-operation reset, start kept high afterwards
        set_ch(0, 0, 2, 4, 0);
        set_ch(1, 2, 1, 2, 0);
        start = 4'b0011;
        run(7);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(6);
        start = '0;
        run(2);
        // randomized traffic with parameters changing every cycle after triggers
        for (int j = 0; j < 1500; j++) begin
            for (int i = 0; i < CH; i++) begin
                set_ch(i, $urandom_range(0, 4), $urandom_range(0, 4),
                       $urandom_range(0, 8), $urandom_range(0, 3));
                if ($urandom_range(0, 11) == 0) start[i] = ~start[i];
            end
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;
        start = '0;
        run(3);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not end by time limit");
        $fatal(1, "timeout");
    end
endmodule
